// File: rtl/sample_dma_master.sv
// Streams 32-bit samples into an SRAM ring buffer over AHB-Lite as single NONSEQ word writes.
// Latency: sample pushed at edge N -> NONSEQ after N+1, HWDATA after N+2, write done at N+3.
// Backpressure: sample_ready drops when the FIFO is full; samples offered while full are counted in drop_cnt.
// Optional SAMPLE_DMA_HALF_IRQ_EN adds the half-buffer interrupt; otherwise irq_half is tied low.

module sample_dma_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign pop_dat = mem[rptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

module sample_dma_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          BUF_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         en,
    input  logic                         sample_valid,
    input  logic [31:0]                  sample_data,
    output logic                         sample_ready,
    output logic [31:0]                  HADDR,
    output logic [1:0]                   HTRANS,
    output logic                         HWRITE,
    output logic [2:0]                   HSIZE,
    output logic [2:0]                   HBURST,
    output logic [3:0]                   HPROT,
    output logic                         HMASTLOCK,
    output logic [31:0]                  HWDATA,
    input  logic                         HREADY,
    input  logic                         HRESP,
    output logic [$clog2(BUF_WORDS)-1:0] wr_idx,
    output logic                         irq_wrap,
    output logic                         irq_half,
    output logic                         err,
    output logic [7:0]                   drop_cnt
);
    localparam int IW = $clog2(BUF_WORDS);
    localparam logic [1:0]    IDLE     = 2'b00;
    localparam logic [1:0]    NONSEQ   = 2'b10;
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_WORDS - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN, ST_ERR} state_t;
    state_t state;

    logic [31:0]   a_dat;   // word popped for the current address phase
    logic [IW-1:0] a_idx;
    logic          dp_vld;
    logic [IW-1:0] dp_idx;
    logic [31:0]   fifo_head;
    logic          fifo_full, fifo_empty;
    logic          issue, err_hit, dp_done, flush, push;

    assign issue   = (state == ST_RUN) && en && HREADY && !fifo_empty;
    assign err_hit = (state != ST_ERR) && dp_vld && HRESP && !HREADY;
    assign dp_done = dp_vld && HREADY && !HRESP;
    assign flush   = (state == ST_ERR) && !en;
    assign push    = sample_valid && (!fifo_full || issue);

    sample_dma_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .flush    (flush),
        .push     (push),
        .push_dat (sample_data),
        .pop      (issue),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign sample_ready = !fifo_full;
    assign HWRITE       = (HTRANS == NONSEQ);
    assign HSIZE        = 3'b010;
    assign HBURST       = 3'b000;
    assign HPROT        = 4'b0011;
    assign HMASTLOCK    = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_STOP;
            HTRANS   <= IDLE;
            HADDR    <= BASE_ADDR;
            HWDATA   <= '0;
            a_dat    <= '0;
            a_idx    <= '0;
            dp_vld   <= 1'b0;
            dp_idx   <= '0;
            wr_idx   <= '0;
            err      <= 1'b0;
            irq_wrap <= 1'b0;
            drop_cnt <= '0;
        end else begin
            irq_wrap <= dp_done && (dp_idx == LAST_IDX);
            if (sample_valid && fifo_full && !issue && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            // Address phase advances into the data phase only on a ready edge.
            if (HREADY) begin
                dp_vld <= (HTRANS == NONSEQ);
                if (HTRANS == NONSEQ) begin
                    HWDATA <= a_dat;
                    dp_idx <= a_idx;
                end
            end

            if (issue) begin
                HTRANS <= NONSEQ;
                HADDR  <= BASE_ADDR + 32'({wr_idx, 2'b00});
                a_dat  <= fifo_head;
                a_idx  <= wr_idx;
                wr_idx <= wr_idx + 1'b1;
            end else if (HREADY) begin
                HTRANS <= IDLE;
            end

            case (state)
                ST_STOP:  if (en && !err) state <= ST_RUN;
                ST_RUN:   if (!en) state <= ST_DRAIN;
                ST_DRAIN: if (HTRANS != NONSEQ && (HREADY || !dp_vld)) state <= ST_STOP;
                ST_ERR: begin
                    if (!en) begin
                        state  <= ST_STOP;
                        err    <= 1'b0;
                        wr_idx <= '0;
                    end
                end
                default: state <= ST_STOP;
            endcase

            // First error cycle: cancel the pending address phase before the second cycle.
            if (err_hit) begin
                state  <= ST_ERR;
                err    <= 1'b1;
                HTRANS <= IDLE;
            end
        end
    end

`ifdef SAMPLE_DMA_HALF_IRQ_EN
    localparam logic [IW-1:0] HALF_IDX = IW'(BUF_WORDS / 2 - 1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) irq_half <= 1'b0;
        else          irq_half <= dp_done && (dp_idx == HALF_IDX);
    end
`else
    assign irq_half = 1'b0;
`endif
endmodule

// File: tb/tb_sample_dma_master.sv
// Directed bench for sample_dma_master with a 4-word ring buffer and 4-entry FIFO.
module tb_sample_dma_master;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [1:0]  TI   = 2'b00;
    localparam logic [1:0]  TN   = 2'b10;
`ifdef SAMPLE_DMA_HALF_IRQ_EN
    localparam logic HALF_ON = 1'b1;
`else
    localparam logic HALF_ON = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        en = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        sample_ready, HWRITE, HMASTLOCK, irq_wrap, irq_half, err;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  wr_idx;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    sample_dma_master #(.BASE_ADDR(BASE), .BUF_WORDS(4), .FIFO_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .wr_idx(wr_idx), .irq_wrap(irq_wrap), .irq_half(irq_half), .err(err), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic        e, v;
        logic [31:0] d;
        logic        r;
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  wi;
        logic        wrap, half;
    } vec_t;

    function automatic vec_t mk(logic e, logic v, logic [31:0] d, logic r, logic [1:0] t,
                                logic [31:0] a, logic [31:0] wd, logic [1:0] wi, logic wrap, logic half);
        vec_t x;
        x.e = e; x.v = v; x.d = d; x.r = r; x.t = t; x.a = a; x.wd = wd; x.wi = wi;
        x.wrap = wrap; x.half = half;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [31:0] d, input logic r, input logic p);
        en = e; sample_valid = v; sample_data = d; HREADY = r; HRESP = p;
        @(posedge HCLK);
        #1;
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = mk(1, 0, 32'h0,  1, TI, BASE,       32'h0,  2'd0, 0, 0);
        tbl[1]  = mk(1, 1, 32'hA1, 1, TI, BASE,       32'h0,  2'd0, 0, 0);
        tbl[2]  = mk(1, 1, 32'hA2, 1, TN, BASE,       32'h0,  2'd1, 0, 0);
        tbl[3]  = mk(1, 1, 32'hA3, 1, TN, BASE + 4,   32'hA1, 2'd2, 0, 0);
        tbl[4]  = mk(1, 0, 32'h0,  1, TN, BASE + 8,   32'hA2, 2'd3, 0, 0);
        tbl[5]  = mk(1, 0, 32'h0,  1, TI, BASE + 8,   32'hA3, 2'd3, 0, 1);
        tbl[6]  = mk(1, 0, 32'h0,  1, TI, BASE + 8,   32'hA3, 2'd3, 0, 0);
        tbl[7]  = mk(1, 1, 32'hB1, 1, TI, BASE + 8,   32'hA3, 2'd3, 0, 0);
        tbl[8]  = mk(1, 1, 32'hB2, 1, TN, BASE + 12,  32'hA3, 2'd0, 0, 0);
        tbl[9]  = mk(1, 1, 32'hB3, 1, TN, BASE,       32'hB1, 2'd1, 0, 0);
        tbl[10] = mk(1, 0, 32'h0,  1, TN, BASE + 4,   32'hB2, 2'd2, 1, 0);
        tbl[11] = mk(1, 0, 32'h0,  0, TN, BASE + 4,   32'hB2, 2'd2, 0, 0);
        tbl[12] = mk(1, 0, 32'h0,  0, TN, BASE + 4,   32'hB2, 2'd2, 0, 0);
        tbl[13] = mk(1, 0, 32'h0,  1, TI, BASE + 4,   32'hB3, 2'd2, 0, 0);
        tbl[14] = mk(1, 0, 32'h0,  1, TI, BASE + 4,   32'hB3, 2'd2, 0, 1);
        tbl[15] = mk(1, 0, 32'h0,  1, TI, BASE + 4,   32'hB3, 2'd2, 0, 0);

        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        #1;
        chk("rst htrans", 32'(HTRANS), 32'(TI));
        chk("rst hwrite", 32'(HWRITE), 32'd0);
        chk("rst haddr", HADDR, BASE);
        chk("rst hwdata", HWDATA, 32'd0);
        chk("rst wr_idx", 32'(wr_idx), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst drop", 32'(drop_cnt), 32'd0);
        chk("rst irqs", 32'({irq_wrap, irq_half}), 32'd0);
        chk("rst ready", 32'(sample_ready), 32'd1);
        chk("const sideband", {HSIZE, HBURST, HPROT, HMASTLOCK}, {21'd0, 3'b010, 3'b000, 4'b0011, 1'b0});
        @(posedge HCLK);
        #1;

        // Back-to-back writes, two-cycle wait state, ring wrap.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("v%0d htrans", i), 32'(HTRANS), 32'(tbl[i].t));
            chk($sformatf("v%0d hwrite", i), 32'(HWRITE), 32'(tbl[i].t == TN));
            chk($sformatf("v%0d haddr", i), HADDR, tbl[i].a);
            chk($sformatf("v%0d hwdata", i), HWDATA, tbl[i].wd);
            chk($sformatf("v%0d wr_idx", i), 32'(wr_idx), 32'(tbl[i].wi));
            chk($sformatf("v%0d irq_wrap", i), 32'(irq_wrap), 32'(tbl[i].wrap));
            chk($sformatf("v%0d irq_half", i), 32'(irq_half), 32'(tbl[i].half & HALF_ON));
        end

        // Stall with samples streaming in: fill, then drop and saturate.
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 32'hC0, 0, 0);
            chk($sformatf("stall%0d ready", k), 32'(sample_ready), 32'(k < 4));
            chk($sformatf("stall%0d drop", k), 32'(drop_cnt), 32'((k > 4) ? k - 4 : 0));
        end
        chk("stall htrans", 32'(HTRANS), 32'(TI));
        repeat (300) step(1, 1, 32'hC0, 0, 0);
        chk("drop saturate", 32'(drop_cnt), 32'd255);

        // Drain the full FIFO: indices 2,3,0,1.
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 32'h0, 1, 0);
            chk($sformatf("drain%0d irq_wrap", k), 32'(irq_wrap), 32'(k == 4));
            chk($sformatf("drain%0d irq_half", k), 32'(irq_half), 32'((k == 6) & HALF_ON));
        end
        chk("drain wr_idx", 32'(wr_idx), 32'd2);
        chk("drain ready", 32'(sample_ready), 32'd1);

        // ERROR response on the D1 data phase with D2 pending.
        step(1, 1, 32'hD1, 1, 0);
        step(1, 1, 32'hD2, 1, 0);
        step(1, 0, 32'h0, 1, 0);
        chk("e3 htrans", 32'(HTRANS), 32'(TN));
        chk("e3 haddr", HADDR, BASE + 12);
        chk("e3 hwdata", HWDATA, 32'hD1);
        step(1, 0, 32'h0, 0, 1);
        chk("err1 htrans", 32'(HTRANS), 32'(TI));
        chk("err1 err", 32'(err), 32'd1);
        step(1, 0, 32'h0, 1, 1);
        chk("err2 htrans", 32'(HTRANS), 32'(TI));
        for (int k = 0; k < 3; k++) begin
            step(1, (k == 0), 32'hE1, 1, 0);
            chk($sformatf("errhold%0d htrans", k), 32'(HTRANS), 32'(TI));
            chk($sformatf("errhold%0d err", k), 32'(err), 32'd1);
        end
        step(0, 0, 32'h0, 1, 0);
        chk("errexit err", 32'(err), 32'd0);
        chk("errexit wr_idx", 32'(wr_idx), 32'd0);
        chk("errexit ready", 32'(sample_ready), 32'd1);
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 0);
        chk("flushed htrans", 32'(HTRANS), 32'(TI));

        // Restart at BASE, then disable with a data phase outstanding.
        step(1, 1, 32'hF1, 1, 0);
        step(1, 1, 32'hF2, 1, 0);
        chk("restart htrans", 32'(HTRANS), 32'(TN));
        chk("restart haddr", HADDR, BASE);
        step(1, 1, 32'hF3, 1, 0);
        chk("f2 haddr", HADDR, BASE + 4);
        step(0, 0, 32'h0, 1, 0);
        chk("dis htrans", 32'(HTRANS), 32'(TI));
        chk("dis hwdata", HWDATA, 32'hF2);
        chk("dis wr_idx", 32'(wr_idx), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 32'h0, 1, 0);
            chk($sformatf("stop%0d htrans", k), 32'(HTRANS), 32'(TI));
        end
        chk("stop wr_idx", 32'(wr_idx), 32'd2);
        step(1, 0, 32'h0, 1, 0);
        chk("reen htrans", 32'(HTRANS), 32'(TI));
        step(1, 0, 32'h0, 1, 0);
        chk("resume htrans", 32'(HTRANS), 32'(TN));
        chk("resume haddr", HADDR, BASE + 8);
        chk("resume wr_idx", 32'(wr_idx), 32'd3);

        // Asynchronous reset mid-transfer, between clock edges.
        #3 HRESETn = 1'b0;
        #1;
        chk("arst htrans", 32'(HTRANS), 32'(TI));
        chk("arst haddr", HADDR, BASE);
        chk("arst hwdata", HWDATA, 32'd0);
        chk("arst wr_idx", 32'(wr_idx), 32'd0);
        chk("arst ready", 32'(sample_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
